// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Raster timing generator and pixel-fetch front end. Starts and
//            stops only on frame boundaries, with DE-aligned registered colour.
// Options  : RESO854        - 854 active pixels per line instead of 800
//            VTG_PATTERN_EN - built-in test pattern replaces iRed/iGreen/iBlue
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
`ifdef RESO854
  parameter int HAPIX = 854,
`else
  parameter int HAPIX = 800,
`endif
  parameter int HFPOR = 40,
  parameter int HSPUL = 128,
  parameter int HBPOR = 88,
  parameter int VAPIX = 600,
  parameter int VFPOR = 1,
  parameter int VSPUL = 4,
  parameter int VBPOR = 23
) (
  input  logic        clock_pixel,
  input  logic        reset,
  input  logic        iEnable,
  input  logic [7:0]  iRed,
  input  logic [7:0]  iGreen,
  input  logic [7:0]  iBlue,
  output logic        oRequest,
  output logic [10:0] oX,
  output logic [10:0] oY,
  output logic        SYNC_H,
  output logic        SYNC_V,
  output logic        DE,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic        oFrameStart
);

  localparam logic [10:0] c_H_ACT  = 11'(HAPIX);
  localparam logic [10:0] c_HS_BEG = 11'(HAPIX + HFPOR);
  localparam logic [10:0] c_HS_END = 11'(HAPIX + HFPOR + HSPUL);
  localparam logic [10:0] c_H_LAST = 11'(HAPIX + HFPOR + HSPUL + HBPOR - 1);
  localparam logic [10:0] c_V_ACT  = 11'(VAPIX);
  localparam logic [10:0] c_VS_BEG = 11'(VAPIX + VFPOR);
  localparam logic [10:0] c_VS_END = 11'(VAPIX + VFPOR + VSPUL);
  localparam logic [10:0] c_V_LAST = 11'(VAPIX + VFPOR + VSPUL + VBPOR - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [10:0] r_hcnt;
  logic [10:0] r_vcnt;

  logic        w_running;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_frame_last;
  logic        w_active;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_request;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [7:0]  w_pix_r;
  logic [7:0]  w_pix_g;
  logic [7:0]  w_pix_b;

  logic        r_de;
  logic        r_sync_h;
  logic        r_sync_v;
  logic        r_frame_start;
  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic [7:0]  r_blue;

  assign w_running    = (r_state != ST_IDLE);
  assign w_h_last     = (r_hcnt == c_H_LAST);
  assign w_v_last     = (r_vcnt == c_V_LAST);
  assign w_frame_last = w_h_last && w_v_last;
  assign w_active     = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
  assign w_hsync      = (r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END);
  assign w_vsync      = (r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END);
  assign w_request    = w_active && w_running;
  assign w_x          = w_request ? r_hcnt : 11'd0;
  assign w_y          = w_request ? r_vcnt : 11'd0;

  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // STOPPING keeps the raster running so a dropped enable never truncates a frame.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iEnable) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!iEnable) w_state_next = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (iEnable)           w_state_next = ST_RUN;
        else if (w_frame_last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      r_hcnt <= 11'd0;
      r_vcnt <= 11'd0;
    end else if (!w_running) begin
      r_hcnt <= 11'd0;
      r_vcnt <= 11'd0;
    end else if (w_h_last) begin
      r_hcnt <= 11'd0;
      r_vcnt <= w_v_last ? 11'd0 : r_vcnt + 11'd1;
    end else begin
      r_hcnt <= r_hcnt + 11'd1;
    end
  end

`ifdef VTG_PATTERN_EN
  logic w_unused_pattern;
  assign w_unused_pattern = ^{iRed, iGreen, iBlue, w_x[10:8], w_y[10:8]};
  assign w_pix_r = {w_x[5:0] & {6{w_y[4:3] == ~w_x[4:3]}}, 2'b00};
  assign w_pix_g = w_x[7:0] & {8{w_y[6]}};
  assign w_pix_b = w_y[7:0];
`else
  assign w_pix_r = iRed;
  assign w_pix_g = iGreen;
  assign w_pix_b = iBlue;
`endif

  // Single output stage: everything lands one clock after the request cycle.
  always_ff @(posedge clock_pixel or posedge reset) begin
    if (reset) begin
      r_de          <= 1'b0;
      r_sync_h      <= 1'b1;
      r_sync_v      <= 1'b1;
      r_frame_start <= 1'b0;
      r_red         <= 8'd0;
      r_green       <= 8'd0;
      r_blue        <= 8'd0;
    end else begin
      r_de          <= w_request;
      r_sync_h      <= ~(w_hsync && w_running);
      r_sync_v      <= ~(w_vsync && w_running);
      r_frame_start <= w_request && (r_hcnt == 11'd0) && (r_vcnt == 11'd0);
      r_red         <= w_request ? w_pix_r : 8'd0;
      r_green       <= w_request ? w_pix_g : 8'd0;
      r_blue        <= w_request ? w_pix_b : 8'd0;
    end
  end

  assign oRequest    = w_request;
  assign oX          = w_x;
  assign oY          = w_y;
  assign DE          = r_de;
  assign SYNC_H      = r_sync_h;
  assign SYNC_V      = r_sync_v;
  assign oFrameStart = r_frame_start;
  assign oRed        = r_red;
  assign oGreen      = r_green;
  assign oBlue       = r_blue;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Purpose  : Self-checking bench: small-raster vector table and run/stop/reset
//            sequences, default-size line timing, and colour path at (16,72).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Small raster: HTOTAL = 8+2+3+2 = 15, VTOTAL = 4+1+2+1 = 8, frame = 120 clocks.
  logic        en_s = 1'b0;
  logic        req_s, sh_s, sv_s, de_s, fs_s;
  logic [10:0] x_s, y_s;
  logic [7:0]  r_s, g_s, b_s;
  logic [7:0]  ri_s, gi_s;
  assign ri_s = x_s[7:0];
  assign gi_s = y_s[7:0];

  video_timing_gen #(
    .HAPIX(8), .HFPOR(2), .HSPUL(3), .HBPOR(2),
    .VAPIX(4), .VFPOR(1), .VSPUL(2), .VBPOR(1)
  ) u_small (
    .clock_pixel(clk), .reset(rst), .iEnable(en_s),
    .iRed(ri_s), .iGreen(gi_s), .iBlue(8'hA5),
    .oRequest(req_s), .oX(x_s), .oY(y_s),
    .SYNC_H(sh_s), .SYNC_V(sv_s), .DE(de_s),
    .oRed(r_s), .oGreen(g_s), .oBlue(b_s), .oFrameStart(fs_s)
  );

  // Default-size raster for line timing.
  logic        en_f = 1'b0;
  logic        req_f, sh_f, sv_f, de_f, fs_f;
  logic [10:0] x_f, y_f;
  logic [7:0]  r_f, g_f, b_f;

  video_timing_gen u_full (
    .clock_pixel(clk), .reset(rst), .iEnable(en_f),
    .iRed(8'h00), .iGreen(8'h00), .iBlue(8'h00),
    .oRequest(req_f), .oX(x_f), .oY(y_f),
    .SYNC_H(sh_f), .SYNC_V(sv_f), .DE(de_f),
    .oRed(r_f), .oGreen(g_f), .oBlue(b_f), .oFrameStart(fs_f)
  );

  // Wide enough to reach pixel (16,72): HTOTAL = 35, VTOTAL = 83.
  logic        en_p = 1'b0;
  logic        req_p, sh_p, sv_p, de_p, fs_p;
  logic [10:0] x_p, y_p;
  logic [7:0]  r_p, g_p, b_p;

  video_timing_gen #(
    .HAPIX(32), .HFPOR(1), .HSPUL(1), .HBPOR(1),
    .VAPIX(80), .VFPOR(1), .VSPUL(1), .VBPOR(1)
  ) u_pat (
    .clock_pixel(clk), .reset(rst), .iEnable(en_p),
    .iRed(8'h5A), .iGreen(8'hC3), .iBlue(8'h3C),
    .oRequest(req_p), .oX(x_p), .oY(y_p),
    .SYNC_H(sh_p), .SYNC_V(sv_p), .DE(de_p),
    .oRed(r_p), .oGreen(g_p), .oBlue(b_p), .oFrameStart(fs_p)
  );

  typedef struct {
    int n;
    bit en;
    bit req; int x; int y;
    bit de; bit sh; bit sv; bit fs;
    int r; int g; int b;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, ".req"}, int'(req_s), 0);
    check({tag, ".x"},   int'(x_s),   0);
    check({tag, ".y"},   int'(y_s),   0);
    check({tag, ".de"},  int'(de_s),  0);
    check({tag, ".sh"},  int'(sh_s),  1);
    check({tag, ".sv"},  int'(sv_s),  1);
    check({tag, ".fs"},  int'(fs_s),  0);
    check({tag, ".r"},   int'(r_s),   0);
    check({tag, ".g"},   int'(g_s),   0);
    check({tag, ".b"},   int'(b_s),   0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int de_cnt, req_cnt, sv_low, fs_cnt, found, t;
    int de_fall0, de_rise1, sh_fall0, sh_rise0, svl_f;
    logic prev_de, prev_sh;

    // n, en, req, x, y, de, sh, sv, fs, r, g, b
    tbl[0]  = '{1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1,  1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1,  1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 'hA5};
    tbl[3]  = '{1,  1, 1, 2, 0, 1, 1, 1, 0, 1, 0, 'hA5};
    tbl[4]  = '{5,  1, 1, 7, 0, 1, 1, 1, 0, 6, 0, 'hA5};
    tbl[5]  = '{1,  1, 0, 0, 0, 1, 1, 1, 0, 7, 0, 'hA5};
    tbl[6]  = '{1,  1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{1,  1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[8]  = '{1,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{2,  1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[10] = '{1,  1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[11] = '{1,  1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0};
    tbl[12] = '{1,  1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 'hA5};
    tbl[13] = '{60, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[14] = '{29, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[15] = '{1,  1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[16] = '{14, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[17] = '{1,  1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 'hA5};

    step(2);
    check_small_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      en_s = tbl[i].en;
      step(tbl[i].n);
      check($sformatf("row%0d.req", i), int'(req_s), int'(tbl[i].req));
      check($sformatf("row%0d.x", i),   int'(x_s),   tbl[i].x);
      check($sformatf("row%0d.y", i),   int'(y_s),   tbl[i].y);
      check($sformatf("row%0d.de", i),  int'(de_s),  int'(tbl[i].de));
      check($sformatf("row%0d.sh", i),  int'(sh_s),  int'(tbl[i].sh));
      check($sformatf("row%0d.sv", i),  int'(sv_s),  int'(tbl[i].sv));
      check($sformatf("row%0d.fs", i),  int'(fs_s),  int'(tbl[i].fs));
      check($sformatf("row%0d.r", i),   int'(r_s),   tbl[i].r);
      check($sformatf("row%0d.g", i),   int'(g_s),   tbl[i].g);
      check($sformatf("row%0d.b", i),   int'(b_s),   tbl[i].b);
    end

    // Drop enable at (0,2): lines 2..7 must still run, then idle.
    step(29);
    en_s = 1'b0;
    de_cnt = 0; req_cnt = 0; sv_low = 0; fs_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      de_cnt  += int'(de_s);
      req_cnt += int'(req_s);
      sv_low  += int'(!sv_s);
      fs_cnt  += int'(fs_s);
    end
    check("stop.de_count",  de_cnt,  16);
    check("stop.req_count", req_cnt, 15);
    check("stop.sv_low",    sv_low,  30);
    check("stop.fs_count",  fs_cnt,  0);
    check_small_reset("stop.idle");

    en_s = 1'b1;
    step(1);
    check("restart.req", int'(req_s), 1);
    check("restart.x",   int'(x_s),   0);
    check("restart.y",   int'(y_s),   0);
    step(1);
    check("restart.de", int'(de_s), 1);
    check("restart.fs", int'(fs_s), 1);

    // Enable glitch low across lines 1..2: next frame start exactly one frame later.
    step(14);
    en_s = 1'b0;
    step(30);
    en_s = 1'b1;
    found = 0;
    for (int i = 1; i <= 300 && found == 0; i++) begin
      step(1);
      if (fs_s) found = 44 + i;
    end
    check("reenable.frame_period", found, 120);

    // Asynchronous reset in the middle of an active line at (5,1).
    step(19);
    check("areset.pre_de", int'(de_s), 1);
    check("areset.pre_r",  int'(r_s),  4);
    check("areset.pre_g",  int'(g_s),  1);
    #3 rst = 1'b1;
    #1 check_small_reset("areset");
    en_s = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);
    check_small_reset("areset.idle");
    en_s = 1'b1;
    step(1);
    check("areset.restart_req", int'(req_s), 1);
    check("areset.restart_x",   int'(x_s),   0);
    check("areset.restart_y",   int'(y_s),   0);
    step(1);
    check("areset.restart_de", int'(de_s), 1);
    check("areset.restart_fs", int'(fs_s), 1);

    // Asynchronous reset while both syncs are low at (12,5).
    step(86);
    check("areset2.pre_sh", int'(sh_s), 0);
    check("areset2.pre_sv", int'(sv_s), 0);
    #3 rst = 1'b1;
    #1 check_small_reset("areset2");
    en_s = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Default raster: first two lines of line timing.
    en_f = 1'b1;
    step(1);
    check("full.first_req", int'(req_f), 1);
    check("full.first_de0", int'(de_f),  0);
    step(1);
    check("full.first_de",  int'(de_f), 1);
    check("full.first_fs",  int'(fs_f), 1);
    de_fall0 = -1; de_rise1 = -1; sh_fall0 = -1; sh_rise0 = -1; svl_f = 0;
    prev_de = de_f; prev_sh = sh_f;
    for (t = 3; t <= 1200; t++) begin
      step(1);
      if (prev_de && !de_f && de_fall0 < 0) de_fall0 = t;
      if (!prev_de && de_f && de_rise1 < 0) de_rise1 = t;
      if (prev_sh && !sh_f && sh_fall0 < 0) sh_fall0 = t;
      if (!prev_sh && sh_f && sh_rise0 < 0) sh_rise0 = t;
      svl_f += int'(!sv_f);
      prev_de = de_f;
      prev_sh = sh_f;
    end
    check("full.de_width",   de_fall0 - 2,        800);
    check("full.line_period", de_rise1 - 2,       1056);
    check("full.hfp",        sh_fall0 - de_fall0, 40);
    check("full.hsync_width", sh_rise0 - sh_fall0, 128);
    check("full.sv_low",     svl_f,               0);
    en_f = 1'b0;

    // Colour path at pixel (16,72).
    en_p = 1'b1;
    step(1);
    step(2536);
    check("pix.req", int'(req_p), 1);
    check("pix.x",   int'(x_p),   16);
    check("pix.y",   int'(y_p),   72);
    step(1);
    check("pix.de",  int'(de_p),  1);
`ifdef VTG_PATTERN_EN
    check("pix.r", int'(r_p), 'h40);
    check("pix.g", int'(g_p), 'h10);
    check("pix.b", int'(b_p), 'h48);
`else
    check("pix.r", int'(r_p), 'h5A);
    check("pix.g", int'(g_p), 'hC3);
    check("pix.b", int'(b_p), 'h3C);
`endif
    en_p = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator and pixel-fetch front end for the single-link HDMI path. It produces active-low horizontal/vertical sync and data-enable for the TMDS encoder stage, which consumes `SYNC_H`, `SYNC_V`, `DE` and 8-bit RGB. It issues a one-cycle-ahead pixel request with X/Y coordinates to the pixel source and registers the returned colour so that colour is aligned with `DE`. A run/stop controller starts and stops output only on frame boundaries.

## Interface
- `HAPIX`, 800, active pixels per line (854 when `RESO854` is defined)
- `HFPOR`, 40, horizontal front porch (clocks)
- `HSPUL`, 128, horizontal sync pulse width
- `HBPOR`, 88, horizontal back porch
- `VAPIX`, 600, active lines
- `VFPOR`, 1, vertical front porch (lines)
- `VSPUL`, 4, vertical sync width (lines)
- `VBPOR`, 23, vertical back porch (lines)
- `clock_pixel`  in  1  pixel clock; every flop is clocked on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `iEnable`  in  1  run request (level-sensitive)
- `iRed`, `iGreen`, `iBlue`  in  8 each  pixel colour, sampled in the cycle when `oRequest`=1
- `oRequest`  out  1  pixel request; valid coordinates on `oX`/`oY`
- `oX`, `oY`  out  11 each  coordinates of the requested pixel
- `SYNC_H`, `SYNC_V`  out  1 each  syncs, active low
- `DE`  out  1  data enable
- `oRed`, `oGreen`, `oBlue`  out  8 each  colour aligned with `DE`
- `oFrameStart`  out  1  one-cycle pulse with the first `DE` of each frame

## Operation
- Totals: HTOTAL = HAPIX+HFPOR+HSPUL+HBPOR (1056); VTOTAL = VAPIX+VFPOR+VSPUL+VBPOR (628). Counters `hcnt` and `vcnt` are 11 bits wide.
- `hcnt` counts 0..HTOTAL-1 and wraps to 0. `vcnt` increments when `hcnt` wraps, and wraps to 0 after VTOTAL-1.
- Regions, as functions of (`hcnt`,`vcnt`):
  - active: `hcnt`<HAPIX && `vcnt`<VAPIX
  - hsync: HAPIX+HFPOR ≤ `hcnt` < HAPIX+HFPOR+HSPUL
  - vsync: VAPIX+VFPOR ≤ `vcnt` < VAPIX+VFPOR+VSPUL
- The FSM has three states: IDLE, RUN and STOPPING.
  - IDLE: counters held at 0,0; `SYNC_H`=`SYNC_V`=1; `DE`=0. Goes to RUN when `iEnable`=1.
  - RUN: counters advance. When `iEnable`=0, goes to STOPPING.
  - STOPPING: counters advance. At `hcnt`=HTOTAL-1 && `vcnt`=VTOTAL-1, goes to IDLE. If `iEnable` returns to 1 before then, goes back to RUN with no break in the frame.
- `oRequest` is combinational: active region && state≠IDLE. `oX`=`hcnt` and `oY`=`vcnt` when `oRequest`=1, else 0.
- Output stage is one register stage. `DE` = registered `oRequest`. `SYNC_H`/`SYNC_V` = registered inverted hsync/vsync, gated by state≠IDLE.
- Colour register:
  - loads `iRed`/`iGreen`/`iBlue` when `oRequest`=1
  - otherwise loads 0
  - colour is therefore zero whenever `DE`=0
- `oFrameStart` = registered (`oRequest` && `hcnt`==0 && `vcnt`==0).

## Timing
- Reset values: `SYNC_H`=1, `SYNC_V`=1, `DE`=0, `oRequest`=0, `oX`=`oY`=0, colour outputs 0, `oFrameStart`=0, state IDLE, counters 0.
- Latency:
  - `oRequest` → `DE`: 1 clock
  - `iRed`/`iGreen`/`iBlue` → `oRed`/`oGreen`/`oBlue`: 1 clock
  - `iEnable` rise → first `oRequest`: 1 clock (the IDLE→RUN edge), at (0,0)
- Line period is HTOTAL clocks. `DE` is high for HAPIX consecutive clocks per active line. `SYNC_H` is low for HSPUL clocks, starting HFPOR clocks after `DE` falls.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronously). After reset releases, the generator restarts from (0,0) on the next `iEnable`.
- `iEnable` falling mid-frame: the current frame completes in full, including blanking. There is no truncated frame.

## Configuration
- `VTG_PATTERN_EN` defined: `iRed`/`iGreen`/`iBlue` are ignored. The colour register loads a built-in pattern when `oRequest`=1:
  - red = {`oX`[5:0] & {6{`oY`[4:3]==~`oX`[4:3]}}, 2'b00}
  - green = `oX`[7:0] & {8{`oY`[6]}}
  - blue = `oY`[7:0]
- `VTG_PATTERN_EN` undefined: the colour register loads `iRed`/`iGreen`/`iBlue` as described above. No pattern logic is present.

## Test plan
- Reset, then `iEnable`=1: first `DE`=1 two clocks after the enable edge; `oFrameStart` pulses once. `DE` has 800 high clocks per line and lines repeat every 1056 clocks.
- Measure one frame: 600 lines with `DE`; `SYNC_H` low for 128 clocks starting 40 clocks after `DE` falls; `SYNC_V` low for lines 601..604 (4×1056 clocks); frame = 628×1056 = 663168 clocks.
- Drive `iRed`=`oX`[7:0], `iGreen`=`oY`[7:0], `iBlue`=8'hA5: check `oRed`/`oGreen` equal the coordinates of the previous cycle's request, `oBlue`=8'hA5 during `DE`, and all colour outputs 0 during blanking.
- Drop `iEnable` at line 300: frame runs to (1055,627), then outputs idle (`SYNC_H`=`SYNC_V`=1). Re-assert `iEnable` during line 400 of that frame: no idle gap occurs and the next frame starts normally.
- Assert `reset` mid-line: all outputs return to reset values without waiting for a clock edge; after release, restart behaves as in the first scenario.
- With `VTG_PATTERN_EN`: at (`oX`,`oY`)=(0x10,0x48), check `oGreen`=0x10, `oBlue`=0x48, `oRed`=0x40 one clock later.
